// File: rtl/universal_shift_register.sv
// n-bit universal shift register: hold, shift right, shift left, parallel load.
// Define USR_SERIAL_OUT_EN to add the so_right/so_left shifted-out bit ports.
module universal_shift_register #(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [n-1:0] d,
`ifdef USR_SERIAL_OUT_EN
  output logic         so_right,
  output logic         so_left,
`endif
  output logic [n-1:0] q
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [n-1:0] q_q, q_d;

  // Unknown ctrl values fall to the default branch and keep the register stable.
  always_comb begin
    q_d = q_q;
    case (ctrl)
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {d[n-1], q_q[n-1:1]};
      MODE_SHL:  q_d = {q_q[n-2:0], d[0]};
      MODE_LOAD: q_d = d;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef USR_SERIAL_OUT_EN
  logic so_right_q, so_right_d;
  logic so_left_q, so_left_d;

  // Each serial-out bit captures the bit leaving its end; it holds otherwise.
  always_comb begin
    so_right_d = so_right_q;
    so_left_d  = so_left_q;
    case (ctrl)
      MODE_SHR: so_right_d = q_q[0];
      MODE_SHL: so_left_d  = q_q[n-1];
      default: begin
        so_right_d = so_right_q;
        so_left_d  = so_left_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      so_right_q <= 1'b0;
      so_left_q  <= 1'b0;
    end else begin
      so_right_q <= so_right_d;
      so_left_q  <= so_left_d;
    end
  end

  assign so_right = so_right_q;
  assign so_left  = so_left_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (n=8): directed cases plus
// randomized traffic against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic [1:0]   ctrl;
  logic [N-1:0] d;
  logic [N-1:0] q;
`ifdef USR_SERIAL_OUT_EN
  logic         so_right;
  logic         so_left;
`endif

  int checks;
  int errors;

  // Reference state
  int unsigned m_q;
  int unsigned m_sr;
  int unsigned m_sl;

  universal_shift_register #(.n(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .ctrl    (ctrl),
    .d       (d),
`ifdef USR_SERIAL_OUT_EN
    .so_right(so_right),
    .so_left (so_left),
`endif
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model update written with plain integer arithmetic on the register value.
  task automatic model_step(input int unsigned c, input int unsigned din);
    int unsigned mask;
    int unsigned old;
    mask = (1 << N) - 1;
    old  = m_q;
    case (c)
      1: begin
        m_q  = (old / 2) + (((din >> (N - 1)) & 1) * (1 << (N - 1)));
        m_sr = old % 2;
      end
      2: begin
        m_q  = ((old * 2) & mask) + (din % 2);
        m_sl = (old >> (N - 1)) & 1;
      end
      3: m_q = din & mask;
      default: m_q = old;
    endcase
  endtask

  task automatic step(input logic [1:0] c, input logic [N-1:0] din, input string tag);
    ctrl = c;
    d    = din;
    @(posedge clock);
    model_step(c, din);
    #1;
    chk(tag, q, m_q);
`ifdef USR_SERIAL_OUT_EN
    chk({tag, "_sor"}, so_right, m_sr);
    chk({tag, "_sol"}, so_left, m_sl);
`endif
  endtask

  task automatic async_reset_pulse(input string tag);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk(tag, q, 0);
`ifdef USR_SERIAL_OUT_EN
    chk({tag, "_sor"}, so_right, 0);
    chk({tag, "_sol"}, so_left, 0);
`endif
    reset = 1'b0;
    m_q = 0; m_sr = 0; m_sl = 0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_q = 0; m_sr = 0; m_sl = 0;
    reset = 1'b1;
    ctrl  = 2'b11;
    d     = 8'hFF;
    #1;
    chk("reset_q", q, 0);
    // Clock edges during reset must not load anything.
    @(posedge clock); #1;
    chk("reset_held", q, 0);
    @(negedge clock);
    reset = 1'b0;

    step(2'b01, 8'b11011011, "shr_from_zero");
    chk("shr_from_zero_lit", q, 8'b10000000);
    step(2'b10, 8'b11011011, "shl_serial");
    chk("shl_serial_lit", q, 8'b00000001);
    step(2'b11, 8'b10101010, "load");
    chk("load_lit", q, 8'b10101010);
    step(2'b00, 8'b01010101, "hold");
    chk("hold_lit", q, 8'b10101010);
    step(2'b01, 8'b10101010, "shr");
    chk("shr_lit", q, 8'b11010101);
    step(2'b10, 8'b01010101, "shl");
    chk("shl_lit", q, 8'b10101011);
    step(2'b11, 8'b11110000, "load2");
    async_reset_pulse("async_reset");

    // Constant serial-in fills the register after n shifts.
    for (int i = 0; i < N; i++) step(2'b01, 8'h80, "fill_right");
    chk("fill_right_lit", q, 8'hFF);
    for (int i = 0; i < N; i++) step(2'b10, 8'h00, "fill_left");
    chk("fill_left_lit", q, 8'h00);

`ifdef USR_SERIAL_OUT_EN
    step(2'b11, 8'b10000001, "so_load");
    step(2'b01, 8'h00, "so_shr");
    chk("so_shr_bit", so_right, 1);
    chk("so_shr_q", q, 8'b01000000);
    step(2'b10, 8'h00, "so_shl");
    chk("so_shl_bit", so_left, 0);
    chk("so_shl_q", q, 8'b10000000);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        async_reset_pulse("rand_reset");
      end else begin
        step(2'($urandom_range(0, 3)), 8'($urandom), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
